// File: rtl/fetch_seq.sv
// Instruction fetch sequencer: walks a word-indexed ROM from RESET_PC, issuing one
// registered instruction per cycle, with stall hold, branch redirect and halt.
module fetch_seq #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_data,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic [31:0] inst_out,
  output logic [31:0] pc_out,
  output logic        inst_valid,
  output logic        halted,
  output logic [15:0] fetch_count
);

  localparam logic [1:0] BOOT = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HALT = 2'd2;

  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic        vld_q, vld_d;
  logic        halted_q, halted_d;
  logic [15:0] cnt_q, cnt_d;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    inst_d   = inst_q;
    pc_out_d = pc_out_q;
    vld_d    = vld_q;
    cnt_d    = cnt_q;
    case (state_q)
      BOOT: begin
        vld_d   = 1'b0;
        state_d = (RESET_PC >= DEPTH_W) ? HALT : RUN;
      end
      RUN: begin
        // Redirect outranks both stall and the end-of-ROM halt check.
        if (br_taken) begin
          vld_d   = 1'b0;
          pc_d    = br_target;
          state_d = (br_target >= DEPTH_W) ? HALT : RUN;
        end else if (pc_q >= DEPTH_W) begin
          vld_d   = 1'b0;
          state_d = HALT;
        end else if (!stall) begin
          inst_d   = mem_data;
          pc_out_d = pc_q;
          vld_d    = 1'b1;
          pc_d     = pc_q + 32'd1;
          cnt_d    = sat_inc(cnt_q);
        end
      end
      HALT: begin
        vld_d = 1'b0;
        if (br_taken) begin
          pc_d    = br_target;
          state_d = (br_target >= DEPTH_W) ? HALT : RUN;
        end
      end
      default: begin
        vld_d   = 1'b0;
        state_d = BOOT;
      end
    endcase
    halted_d = (state_d == HALT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= BOOT;
      pc_q     <= RESET_PC;
      inst_q   <= 32'd0;
      pc_out_q <= 32'd0;
      vld_q    <= 1'b0;
      halted_q <= 1'b0;
      cnt_q    <= 16'd0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      inst_q   <= inst_d;
      pc_out_q <= pc_out_d;
      vld_q    <= vld_d;
      halted_q <= halted_d;
      cnt_q    <= cnt_d;
    end
  end

  assign mem_addr    = pc_q;
  assign inst_out    = inst_q;
  assign pc_out      = pc_out_q;
  assign inst_valid  = vld_q;
  assign halted      = halted_q;
  assign fetch_count = cnt_q;

endmodule

// File: tb/tb_fetch_seq.sv
// Bench for fetch_seq: expected (instruction, pc) pairs are queued as stimulus is
// driven and retired against each newly issued instruction.
module tb_fetch_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic        stall = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = 32'd0;
  logic [31:0] inst_out;
  logic [31:0] pc_out;
  logic        inst_valid;
  logic        halted;
  logic [15:0] fetch_count;

  int tests = 0;
  int fails = 0;
  int issued = 0;
  logic [63:0] sb[$];
  logic [31:0] last_inst = 32'd0;
  logic [31:0] last_pc = 32'd0;

  always #5 clk = ~clk;

  fetch_seq #(.DEPTH(4), .RESET_PC(32'd0)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .stall      (stall),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .inst_out   (inst_out),
    .pc_out     (pc_out),
    .inst_valid (inst_valid),
    .halted     (halted),
    .fetch_count(fetch_count)
  );

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    case (a)
      32'd0:   return 32'hA000_00A0;
      32'd1:   return 32'hA111_00A1;
      32'd2:   return 32'hA222_00A2;
      32'd3:   return 32'hA333_00A3;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  assign mem_data = rom_word(mem_addr);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic expect_issue(input logic [31:0] pc);
    sb.push_back({rom_word(pc), pc});
  endtask

  // One clock edge; outputs sampled 1 time unit later.
  task automatic step();
    logic st, rs;
    logic [63:0] e;
    st = stall;
    rs = rst;
    @(posedge clk);
    #1;
    if (rs) issued = 0;
    if (inst_valid) begin
      if (!st) begin
        if (sb.size() == 0) begin
          check_eq("sb_underflow", 32'(sb.size()), 32'd1);
        end else begin
          e = sb.pop_front();
          issued++;
          check_eq("issue_inst", inst_out, e[63:32]);
          check_eq("issue_pc", pc_out, e[31:0]);
          last_inst = e[63:32];
          last_pc = e[31:0];
        end
      end else begin
        check_eq("held_inst", inst_out, last_inst);
        check_eq("held_pc", pc_out, last_pc);
      end
    end
    check_eq("fetch_count", 32'(fetch_count), 32'(issued));
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_inst", inst_out, 32'd0);
    check_eq("rst_pc_out", pc_out, 32'd0);
    check_eq("rst_valid", 32'(inst_valid), 32'd0);
    check_eq("rst_halted", 32'(halted), 32'd0);
    check_eq("rst_mem_addr", mem_addr, 32'd0);
  endtask

  initial begin
    // Reset state
    step();
    step();
    check_reset_outputs();

    // BOOT cycle, with a redirect that must be ignored
    rst = 1'b0;
    br_taken = 1'b1;
    br_target = 32'd3;
    step();
    check_eq("boot_valid", 32'(inst_valid), 32'd0);
    check_eq("boot_br_ignored", mem_addr, 32'd0);
    br_taken = 1'b0;

    // Straight-line run to the end of the ROM
    for (int i = 0; i < 4; i++) expect_issue(32'(i));
    for (int i = 0; i < 4; i++) step();
    step();
    check_eq("end_halted", 32'(halted), 32'd1);
    check_eq("end_valid", 32'(inst_valid), 32'd0);
    check_eq("end_count", 32'(fetch_count), 32'd4);

    // Stall is ignored in HALT; out-of-range redirect keeps it halted
    stall = 1'b1;
    step();
    check_eq("halt_stall", 32'(halted), 32'd1);
    stall = 1'b0;
    br_taken = 1'b1;
    br_target = 32'd7;
    step();
    check_eq("halt_br7_halted", 32'(halted), 32'd1);
    check_eq("halt_br7_valid", 32'(inst_valid), 32'd0);
    check_eq("halt_br7_addr", mem_addr, 32'd7);

    // In-range redirect resumes after one bubble
    br_target = 32'd1;
    step();
    check_eq("resume_halted", 32'(halted), 32'd0);
    check_eq("resume_bubble", 32'(inst_valid), 32'd0);
    br_taken = 1'b0;
    expect_issue(32'd1);
    step();

    // Three stall cycles holding A1
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("stall_valid", 32'(inst_valid), 32'd1);
      check_eq("stall_addr", mem_addr, 32'd2);
    end
    stall = 1'b0;
    expect_issue(32'd2);
    step();

    // Redirect beats stall
    stall = 1'b1;
    br_taken = 1'b1;
    br_target = 32'd0;
    step();
    check_eq("br_flush_valid", 32'(inst_valid), 32'd0);
    check_eq("br_flush_addr", mem_addr, 32'd0);
    stall = 1'b0;
    br_taken = 1'b0;
    expect_issue(32'd0);
    step();
    expect_issue(32'd1);
    step();

    // Reset in the middle of a stall discards the held instruction
    stall = 1'b1;
    step();
    rst = 1'b1;
    step();
    check_reset_outputs();
    check_eq("rst_count", 32'(fetch_count), 32'd0);
    rst = 1'b0;
    stall = 1'b0;
    step();
    check_eq("reboot_valid", 32'(inst_valid), 32'd0);
    expect_issue(32'd0);
    step();
    check_eq("reboot_count", 32'(fetch_count), 32'd1);
    expect_issue(32'd1);
    step();

    // Redirect out of range from RUN goes straight to HALT
    br_taken = 1'b1;
    br_target = 32'd9;
    step();
    check_eq("run_br9_halted", 32'(halted), 32'd1);
    check_eq("run_br9_valid", 32'(inst_valid), 32'd0);
    check_eq("run_br9_addr", mem_addr, 32'd9);
    br_taken = 1'b0;
    step();
    check_eq("sb_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
